// File: rtl/rf_op_sequencer.sv
// Register-transfer micro-op sequencer: reads two registers, computes a result
// and writes it back through the 8x16 register-file port.
module rf_op_sequencer #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_aa,
   input  logic [ADDR_W-1:0] cmd_ba,
   input  logic [ADDR_W-1:0] cmd_da,
   input  logic [DATA_W-1:0] cmd_imm,
   output logic [ADDR_W-1:0] AA,
   output logic [ADDR_W-1:0] BA,
   output logic [ADDR_W-1:0] DA,
   output logic [DATA_W-1:0] DD,
   output logic              RW,
   input  logic [DATA_W-1:0] AD,
   input  logic [DATA_W-1:0] BD,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              flag_z,
   output logic              flag_c
);

   localparam logic [2:0] OP_MOV = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_SUB = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_OR  = 3'd4;
   localparam logic [2:0] OP_XOR = 3'd5;
   localparam logic [2:0] OP_LDI = 3'd6;
   localparam logic [2:0] OP_CMP = 3'd7;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

   state_t              state_q, state_d;
   logic [2:0]          op_q;
   logic [ADDR_W-1:0]   da_q;
   logic [DATA_W-1:0]   imm_q, opa_q, opb_q;
   logic [DATA_W:0]     res_c;

   logic                ready_d, rw_d, done_d, flag_z_d, flag_c_d;
   logic [ADDR_W-1:0]   aa_d, ba_d, da_d;
   logic [DATA_W-1:0]   dd_d, result_d;

   // State register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (cmd_valid) state_d = S_READ;
         S_READ:  state_d = S_EXEC;
         S_EXEC:  state_d = (op_q == OP_CMP) ? S_IDLE : S_WRITE;
         S_WRITE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ALU, one extra bit so ADD carry and SUB/CMP borrow fall out of bit DATA_W
   always_comb begin
      res_c = '0;
      case (op_q)
         OP_MOV:         res_c = {1'b0, opa_q};
         OP_ADD:         res_c = {1'b0, opa_q} + {1'b0, opb_q};
         OP_SUB, OP_CMP: res_c = {1'b0, opa_q} - {1'b0, opb_q};
         OP_AND:         res_c = {1'b0, opa_q & opb_q};
         OP_OR:          res_c = {1'b0, opa_q | opb_q};
         OP_XOR:         res_c = {1'b0, opa_q ^ opb_q};
         OP_LDI:         res_c = {1'b0, imm_q};
         default:        res_c = '0;
      endcase
   end

   // Output logic: next values of the registered outputs
   always_comb begin
      ready_d  = (state_d == S_IDLE);
      rw_d     = (state_d == S_WRITE);
      done_d   = (state_d == S_WRITE) || (state_d == S_EXEC && op_q == OP_CMP);
      aa_d     = AA;
      ba_d     = BA;
      da_d     = DA;
      dd_d     = DD;
      result_d = result;
      flag_z_d = flag_z;
      flag_c_d = flag_c;
      if (state_q == S_IDLE && cmd_valid) begin
         aa_d = cmd_aa;
         ba_d = cmd_ba;
      end
      if (state_q == S_EXEC) begin
         result_d = res_c[DATA_W-1:0];
         flag_z_d = (res_c[DATA_W-1:0] == '0);
         flag_c_d = (op_q == OP_ADD || op_q == OP_SUB || op_q == OP_CMP) ? res_c[DATA_W] : 1'b0;
         if (op_q != OP_CMP) begin
            da_d = da_q;
            dd_d = res_c[DATA_W-1:0];
         end
      end
   end

   // Output and datapath registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cmd_ready <= 1'b1;
         AA        <= '0;
         BA        <= '0;
         DA        <= '0;
         DD        <= '0;
         RW        <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         flag_z    <= 1'b0;
         flag_c    <= 1'b0;
         op_q      <= '0;
         da_q      <= '0;
         imm_q     <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
      end else begin
         cmd_ready <= ready_d;
         AA        <= aa_d;
         BA        <= ba_d;
         DA        <= da_d;
         DD        <= dd_d;
         RW        <= rw_d;
         done      <= done_d;
         result    <= result_d;
         flag_z    <= flag_z_d;
         flag_c    <= flag_c_d;
         if (state_q == S_IDLE && cmd_valid) begin
            op_q  <= cmd_op;
            da_q  <= cmd_da;
            imm_q <= cmd_imm;
         end
         if (state_q == S_READ) begin
            opa_q <= AD;
            opb_q <= BD;
         end
      end
   end

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Bench for rf_op_sequencer: register-file model plus an op-timeline reference
// model compared every cycle, with directed literal checks.
module tb_rf_op_sequencer;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op = '0;
   logic [2:0]  cmd_aa = '0, cmd_ba = '0, cmd_da = '0;
   logic [15:0] cmd_imm = '0;
   logic [2:0]  AA, BA, DA;
   logic [15:0] DD, AD, BD, result;
   logic        RW, done, flag_z, flag_c;

   always #5 CLK = ~CLK;

   rf_op_sequencer #(.DATA_W(16), .ADDR_W(3)) dut (
      .CLK(CLK), .RESET(RESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_aa(cmd_aa), .cmd_ba(cmd_ba), .cmd_da(cmd_da), .cmd_imm(cmd_imm),
      .AA(AA), .BA(BA), .DA(DA), .DD(DD), .RW(RW), .AD(AD), .BD(BD),
      .done(done), .result(result), .flag_z(flag_z), .flag_c(flag_c)
   );

   // Register file the sequencer talks to
   logic [15:0] rf [8] = '{default: 16'h0};
   assign AD = rf[AA];
   assign BD = rf[BA];
   always @(posedge CLK) if (RW) rf[DA] <= DD;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural registers plus the position of the current op
   logic [15:0] mregs [8] = '{default: 16'h0};
   bit          busy = 0;
   int          c = 0;   // 1 = read cycle, 2 = exec cycle, 3 = write cycle
   logic [2:0]  e_op, e_aa, e_ba, e_da;
   logic [15:0] e_res;
   logic        e_cf, e_zf;
   logic [15:0] cur_res = '0, last_dd = '0;
   logic        cur_z = 0, cur_c = 0;
   logic [2:0]  last_aa = '0, last_ba = '0, last_da = '0;

   function automatic logic [16:0] model_op(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic [15:0] imm);
      int unsigned s;
      case (op)
         3'd0: return {1'b0, a};
         3'd1: begin s = int'(a) + int'(b); return {s[16], s[15:0]}; end
         3'd2, 3'd7: return {a < b, 16'(a - b)};
         3'd3: return {1'b0, a & b};
         3'd4: return {1'b0, a | b};
         3'd5: return {1'b0, a ^ b};
         default: return {1'b0, imm};
      endcase
   endfunction

   always @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         busy = 0; c = 0; cur_res = '0; cur_z = 0; cur_c = 0;
         last_aa = '0; last_ba = '0; last_da = '0; last_dd = '0;
      end else if (busy) begin
         if ((e_op == 3'd7 && c == 2) || c == 3) begin
            if (e_op != 3'd7) begin
               mregs[e_da] = e_res; last_da = e_da; last_dd = e_res;
            end
            cur_res = e_res; cur_z = e_zf; cur_c = e_cf;
            busy = 0; c = 0;
         end else c++;
      end else if (cmd_valid) begin
         busy = 1; c = 1;
         e_op = cmd_op; e_aa = cmd_aa; e_ba = cmd_ba; e_da = cmd_da;
         {e_cf, e_res} = model_op(cmd_op, mregs[cmd_aa], mregs[cmd_ba], cmd_imm);
         if (!(cmd_op inside {3'd1, 3'd2, 3'd7})) e_cf = 1'b0;
         e_zf = (e_res == 16'h0);
         last_aa = cmd_aa; last_ba = cmd_ba;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge CLK) begin
      if (!RESET) begin
         chk("cmd_ready", cmd_ready, !busy);
         chk("RW", RW, busy && c == 3);
         chk("done", done, busy && (e_op == 3'd7 ? c == 2 : c == 3));
         chk("AA", AA, last_aa);
         chk("BA", BA, last_ba);
         chk("DA", DA, (busy && c == 3) ? e_da : last_da);
         chk("DD", DD, (busy && c == 3) ? e_res : last_dd);
         chk("result", result, (busy && c == 3) ? e_res : cur_res);
         chk("flag_z", flag_z, (busy && c == 3) ? e_zf : cur_z);
         chk("flag_c", flag_c, (busy && c == 3) ? e_cf : cur_c);
      end
   end

   // Presents a command from a falling edge and returns at the falling edge after acceptance
   task automatic issue(input logic [2:0] op, input logic [2:0] aa, input logic [2:0] ba,
                        input logic [2:0] da, input logic [15:0] imm, input bit hold);
      int n = 0;
      @(negedge CLK);
      cmd_valid = 1'b1; cmd_op = op; cmd_aa = aa; cmd_ba = ba; cmd_da = da; cmd_imm = imm;
      while (!cmd_ready && n < 20) begin @(negedge CLK); n++; end
      if (n >= 20) chk("accept_timeout", 32'd0, 32'd1);
      @(negedge CLK);
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 20) begin @(negedge CLK); n++; end
      if (n >= 20) chk("idle_timeout", 32'd0, 32'd1);
      @(negedge CLK);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge CLK);
      RESET = 1'b0;
      #1;
      chk("rst_ready", cmd_ready, 1'b1);
      chk("rst_outs", {AA, BA, DA, DD, RW, done, result, flag_z, flag_c}, 32'h0);
      chk("rst_result", result, 16'h0);

      // Operand setup
      issue(3'd6, 3'd0, 3'd0, 3'd1, 16'hFFFF, 0); wait_idle();
      issue(3'd6, 3'd0, 3'd0, 3'd2, 16'h0001, 0); wait_idle();
      issue(3'd6, 3'd0, 3'd0, 3'd5, 16'h0003, 0); wait_idle();
      issue(3'd6, 3'd0, 3'd0, 3'd6, 16'h0005, 0); wait_idle();

      // LDI latency: read, exec, then write cycle with done
      issue(3'd6, 3'd0, 3'd0, 3'd3, 16'h1234, 0);
      chk("ldi_read_rw", RW, 1'b0);
      @(negedge CLK);
      chk("ldi_exec_rw", RW, 1'b0);
      chk("ldi_exec_done", done, 1'b0);
      @(negedge CLK);
      chk("ldi_write", {RW, done, 5'd0, DA, DD}, {1'b1, 1'b1, 5'd0, 3'd3, 16'h1234});
      @(negedge CLK);
      chk("ldi_after", {RW, done}, 2'b00);
      chk("ldi_r3", rf[3], 16'h1234);

      // ADD wraps to zero with carry
      issue(3'd1, 3'd1, 3'd2, 3'd4, 16'h0, 0);
      repeat (2) @(negedge CLK);
      chk("add_write", {RW, DD, flag_z, flag_c}, {1'b1, 16'h0000, 1'b1, 1'b1});
      wait_idle();

      // SUB with borrow
      issue(3'd2, 3'd5, 3'd6, 3'd7, 16'h0, 0);
      repeat (2) @(negedge CLK);
      chk("sub_write", {RW, DA, DD, flag_z, flag_c}, {1'b1, 3'd7, 16'hFFFE, 1'b0, 1'b1});
      wait_idle();
      chk("sub_r7", rf[7], 16'hFFFE);

      // CMP: done in the exec cycle, no write; flags settle with return to idle
      issue(3'd6, 3'd0, 3'd0, 3'd4, 16'h00AA, 0); wait_idle();
      issue(3'd7, 3'd5, 3'd6, 3'd4, 16'h0, 0);
      @(negedge CLK);
      chk("cmp_done", {done, RW}, 2'b10);
      @(negedge CLK);
      chk("cmp_after", {done, RW, cmd_ready, flag_z, flag_c}, 5'b00101);
      chk("cmp_r4", rf[4], 16'h00AA);

      // Back-to-back with cmd_valid held; ADD R1,R1 -> R1 then consumers of new R1
      issue(3'd1, 3'd1, 3'd1, 3'd1, 16'h0, 1);
      issue(3'd5, 3'd1, 3'd2, 3'd0, 16'h0, 1);
      issue(3'd0, 3'd1, 3'd0, 3'd6, 16'h0, 0);
      wait_idle();
      chk("b2b_r1", rf[1], 16'hFFFE);
      chk("b2b_r0", rf[0], 16'hFFFF);
      chk("b2b_r6", rf[6], 16'hFFFE);

      // Reset during the write cycle: write is lost, outputs clear at once
      issue(3'd6, 3'd0, 3'd0, 3'd2, 16'h5555, 0);
      repeat (2) @(negedge CLK);
      chk("pre_rst_rw", RW, 1'b1);
      #1 RESET = 1'b1;
      #1;
      chk("rst_rw_now", {RW, done}, 2'b00);
      @(negedge CLK);
      #1 RESET = 1'b0;
      @(negedge CLK);
      chk("rst_r2", rf[2], 16'h0001);
      chk("rst2_outs", {AA, BA, DA, DD, RW, done, result, flag_z, flag_c, cmd_ready}, 33'h1);

      // Reset pulse around a valid command: the command is dropped
      cmd_valid = 1'b1; cmd_op = 3'd6; cmd_da = 3'd0; cmd_imm = 16'hABCD;
      #1 RESET = 1'b1;
      @(negedge CLK);
      cmd_valid = 1'b0; RESET = 1'b0;
      repeat (5) @(negedge CLK);
      chk("drop_r0", rf[0], 16'hFFFF);
      chk("drop_ready", cmd_ready, 1'b1);

      // Random ops
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge CLK);
         issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 16'($urandom), 0);
      end
      wait_idle();
      for (int r = 0; r < 8; r++) chk("final_reg", rf[r], mregs[r]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
